linecache_packer: RTL and testbench
===================================

# linecache_packer

Write-side feeder for the composite-video line cache. Accepts a serial 1-bit pixel stream through a valid/ready handshake and packs every four pixels into one 4-bit word. Drives the cache's 4-bit write port (word address, data, clock enable) so the 1-bit read port returns pixels in arrival order. One packer fills one scanline per `line_start` and reports completion to the line scheduler.

## Interface

Parameters:
- `LINE_PIXELS`, default 512: pixels per line; multiple of 4, range 4..512.
- `ADDR_W`, default 7: width of the write word address (512 / 4 = 128 words).

Ports:
- `clk`  in  1  single clock for the block; it also clocks the cache write port.
- `reset`  in  1  synchronous, active-high reset.
- `line_start`  in  1  single-cycle pulse; begins filling a line at word 0.
- `pix_valid`  in  1  `pix_data` is valid this cycle.
- `pix_data`  in  1  pixel bit.
- `pix_ready`  out  1  packer accepts a pixel this cycle (combinational).
- `wr_ce`  out  1  write strobe to the cache write-port clock enable.
- `wr_addr`  out  ADDR_W  write word address.
- `wr_data`  out  4  packed nibble.
- `line_done`  out  1  single-cycle pulse; the last word of a line has been written.
- `busy`  out  1  high while in FILL.
- `overrun`  out  1  sticky error flag: a line was restarted before it completed.

## Operation

- **Reset.** All registered outputs reset to 0: `wr_ce`, `wr_addr`, `wr_data`, `line_done`, `busy`, `overrun`. The FSM resets to IDLE, and the pixel counter and shift register clear to 0.
- **FSM, IDLE.**
  - `pix_ready` = 0.
  - `line_start` → FILL, with pixel counter = 0 and partial nibble cleared.
- **FSM, FILL.**
  - `pix_ready` = !`line_start`.
  - An accept is `pix_valid && pix_ready`.
  - Each accept shifts the bit into nibble position (counter mod 4) and increments the counter.
- **Bit order.** Pixel 4k+i lands in `wr_data[i]` of word k, so `wr_data[0]` holds the earliest pixel.
- **Word write.** On the accept that completes a nibble (counter mod 4 = 3), the next cycle carries:
  - `wr_ce` = 1 for exactly one cycle;
  - `wr_addr` = counter / 4;
  - `wr_data` = the complete nibble.
  - `wr_addr` and `wr_data` hold their last values when `wr_ce` = 0.
- **End of line.** On the accept of pixel `LINE_PIXELS`-1:
  - the FSM moves to IDLE;
  - `line_done` = 1 in the same cycle as the final `wr_ce`.
- **Restart during FILL.** `line_start` in FILL:
  - discards the partial nibble;
  - sets the counter to 0 and stays in FILL;
  - sets `overrun` = 1, which clears only on `reset`;
  - no `line_done` is issued for the aborted line.
- **Simultaneous events.** `line_start` with `pix_valid` in the same cycle: `line_start` wins and the pixel is not accepted.
- **Reset mid-line.** `reset` during FILL returns the FSM to IDLE. No further `wr_ce` occurs, even if a nibble had just completed on the same edge.
- **Counter width.** The counter is clog2(`LINE_PIXELS`)+1 bits and never wraps within a line. `wr_addr` = counter[ADDR_W+1:2].

## Timing

- `pix_ready` is combinational from state and `line_start`. All other outputs are registered.
- Write latency: one cycle from the accept of the 4th bit to `wr_ce`.
- Throughput: one pixel per cycle sustained, which gives one write every 4 cycles.
- Back-pressure is the source's choice: gaps in `pix_valid` are allowed anywhere and only stretch the line.
- Minimum line time is `LINE_PIXELS`+1 cycles, from the `line_start` edge to `line_done`.
- `line_done` pulse width is 1 cycle. A new `line_start` is legal in the cycle `line_done` is high.

## Configuration

- **`LINECACHE_PACKER_MSB_FIRST_EN` defined:** bit order reverses. Pixel 4k+i lands in `wr_data[3-i]`, for caches read MSB-first.
- **Not defined:** LSB-first as described in Operation.
- All handshake, timing and flag behaviour is identical in both builds.

## Test plan

- **Full line.** Reset, `line_start`, then 512 back-to-back pixels in the pattern 1,0,0,0 repeated → 128 `wr_ce` pulses, addresses 0..127 in order, every `wr_data` = 4'b0001. `line_done` coincides with the write to address 127 and `overrun` = 0.
- **Back-pressure.** `pix_valid` toggling 1,0 with pixels 1,1,0,1 → word 0 = 4'b1011 (LSB-first build) and `wr_ce` arrives one cycle after the 4th accept. Repeat with the macro defined → 4'b1101.
- **Abort.** `line_start` after 6 pixels, then 512 pixels → no write for the discarded pixels 4–5, and `overrun` = 1. Word addresses restart at 0 and exactly one `line_done` occurs.
- **Small line.** `LINE_PIXELS`=8 with pixels 1..8 = 1,1,1,1,0,0,0,0 → writes addr0=4'hF, addr1=4'h0, then `line_done`. Pixels offered afterward in IDLE see `pix_ready` = 0.
- **Reset mid-line.** `reset` on the edge where pixel 3 is accepted → no `wr_ce` follows, and all outputs are 0 the next cycle.
- **Same-cycle `line_start` and `pix_valid`.** Both asserted in IDLE and in FILL → pixel not accepted and `pix_ready` = 0 that cycle.

Source files
------------

// File: rtl/linecache_packer.sv
// Serial 1-bit pixel packer feeding the 4-bit write port of the composite-video line cache.
// Define LINECACHE_PACKER_MSB_FIRST_EN to place the earliest pixel of each word in wr_data[3].
module linecache_packer #(
  parameter int LINE_PIXELS = 512,
  parameter int ADDR_W      = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              line_start,
  input  logic              pix_valid,
  input  logic              pix_data,
  output logic              pix_ready,
  output logic              wr_ce,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [3:0]        wr_data,
  output logic              line_done,
  output logic              busy,
  output logic              overrun,
  output logic              o_dbg_state
);

  localparam int CW = $clog2(LINE_PIXELS) + 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [3:0]        r_nib;
  logic              r_wr_ce;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [3:0]        r_wr_data;
  logic              r_line_done;
  logic              r_busy;
  logic              r_overrun;

  logic              w_accept;
  logic              w_word_done;
  logic              w_last_px;
  logic [1:0]        w_pos;
  logic [3:0]        w_nib_next;
  logic [ADDR_W-1:0] w_word_addr;

  // Handshake: a pixel transfers on a cycle where pix_valid && pix_ready; the
  // source may hold or drop pix_valid freely, and a line_start always blocks the transfer.
  assign pix_ready = (r_state == S_FILL) && !line_start;
  assign w_accept  = pix_valid && pix_ready;

  assign w_word_done = (r_cnt[1:0] == 2'd3);
  assign w_last_px   = (r_cnt == CW'(LINE_PIXELS - 1));
  assign w_word_addr = ADDR_W'(r_cnt >> 2);

`ifdef LINECACHE_PACKER_MSB_FIRST_EN
  assign w_pos = 2'd3 - r_cnt[1:0];
`else
  assign w_pos = r_cnt[1:0];
`endif

  always_comb begin
    w_nib_next        = r_nib;
    w_nib_next[w_pos] = pix_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_nib       <= '0;
      r_wr_ce     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_line_done <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_wr_ce     <= 1'b0;
      r_line_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (line_start) begin
            r_state <= S_FILL;
            r_cnt   <= '0;
            r_nib   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_FILL: begin
          if (line_start) begin
            // Restart aborts the current line without reporting it done.
            r_cnt     <= '0;
            r_nib     <= '0;
            r_overrun <= 1'b1;
          end else if (w_accept) begin
            r_cnt <= r_cnt + CW'(1);
            if (w_word_done) begin
              r_nib     <= '0;
              r_wr_ce   <= 1'b1;
              r_wr_addr <= w_word_addr;
              r_wr_data <= w_nib_next;
            end else begin
              r_nib <= w_nib_next;
            end
            if (w_last_px) begin
              r_state     <= S_IDLE;
              r_busy      <= 1'b0;
              r_line_done <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_ce       = r_wr_ce;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign line_done   = r_line_done;
  assign busy        = r_busy;
  assign overrun     = r_overrun;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_linecache_packer.sv
// Bench for linecache_packer: a 512-pixel and an 8-pixel instance share one directed stimulus
// stream and are checked every cycle against a pixel-counting model plus hand-computed literals.
module tb_linecache_packer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic line_start = 1'b0;
  logic pix_valid = 1'b0;
  logic pix_data = 1'b0;

  always #5 clk = ~clk;

  logic       b_rdy, b_ce, b_done, b_busy, b_ovr, b_dbg;
  logic [6:0] b_addr;
  logic [3:0] b_data;
  logic       s_rdy, s_ce, s_done, s_busy, s_ovr, s_dbg;
  logic [0:0] s_addr;
  logic [3:0] s_data;

  linecache_packer #(.LINE_PIXELS(512), .ADDR_W(7)) u_big (
    .clk(clk), .reset(reset), .line_start(line_start), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_ready(b_rdy), .wr_ce(b_ce), .wr_addr(b_addr),
    .wr_data(b_data), .line_done(b_done), .busy(b_busy), .overrun(b_ovr),
    .o_dbg_state(b_dbg)
  );

  linecache_packer #(.LINE_PIXELS(8), .ADDR_W(1)) u_small (
    .clk(clk), .reset(reset), .line_start(line_start), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_ready(s_rdy), .wr_ce(s_ce), .wr_addr(s_addr),
    .wr_data(s_data), .line_done(s_done), .busy(s_busy), .overrun(s_ovr),
    .o_dbg_state(s_dbg)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] order(input logic [3:0] p);
`ifdef LINECACHE_PACKER_MSB_FIRST_EN
    return {p[0], p[1], p[2], p[3]};
`else
    return p;
`endif
  endfunction

  // Model: count accepted pixels of the current line; every 4th one emits word n/4-1.
  int         lp[2] = '{512, 8};
  bit         m_started = 1'b0;
  logic       m_fill[2], m_ce[2], m_done[2], m_busy[2], m_ovr[2];
  int         m_n[2], m_addr[2];
  logic [3:0] m_pend[2], m_data[2];

  always @(posedge clk) begin
    m_started = 1'b1;
    for (int d = 0; d < 2; d++) begin
      m_ce[d]   = 1'b0;
      m_done[d] = 1'b0;
      if (reset) begin
        m_fill[d] = 1'b0; m_n[d] = 0; m_addr[d] = 0; m_data[d] = 4'h0;
        m_busy[d] = 1'b0; m_ovr[d] = 1'b0; m_pend[d] = 4'h0;
      end else if (line_start) begin
        if (m_fill[d]) m_ovr[d] = 1'b1;
        m_fill[d] = 1'b1;
        m_busy[d] = 1'b1;
        m_n[d]    = 0;
      end else if (m_fill[d] && pix_valid) begin
        m_pend[d][m_n[d] % 4] = pix_data;
        m_n[d] = m_n[d] + 1;
        if (m_n[d] % 4 == 0) begin
          m_ce[d]   = 1'b1;
          m_addr[d] = m_n[d] / 4 - 1;
          m_data[d] = order(m_pend[d]);
        end
        if (m_n[d] == lp[d]) begin
          m_fill[d] = 1'b0;
          m_busy[d] = 1'b0;
          m_done[d] = 1'b1;
        end
      end
    end
  end

  logic [6:0] cap_ba[$];
  logic [3:0] cap_bd[$];
  logic [0:0] cap_sa[$];
  logic [3:0] cap_sd[$];
  int         b_done_cnt = 0;
  int         s_done_cnt = 0;

  always @(negedge clk) begin
    if (m_started) begin
      chk("big.wr_ce", b_ce, m_ce[0]);
      chk("big.wr_addr", b_addr, m_addr[0]);
      chk("big.wr_data", b_data, m_data[0]);
      chk("big.line_done", b_done, m_done[0]);
      chk("big.busy", b_busy, m_busy[0]);
      chk("big.overrun", b_ovr, m_ovr[0]);
      chk("big.pix_ready", b_rdy, m_fill[0] && !line_start);
      chk("big.dbg_state", b_dbg, m_fill[0]);
      chk("small.wr_ce", s_ce, m_ce[1]);
      chk("small.wr_addr", s_addr, m_addr[1]);
      chk("small.wr_data", s_data, m_data[1]);
      chk("small.line_done", s_done, m_done[1]);
      chk("small.busy", s_busy, m_busy[1]);
      chk("small.overrun", s_ovr, m_ovr[1]);
      chk("small.pix_ready", s_rdy, m_fill[1] && !line_start);
      chk("small.dbg_state", s_dbg, m_fill[1]);
      if (b_ce === 1'b1) begin cap_ba.push_back(b_addr); cap_bd.push_back(b_data); end
      if (s_ce === 1'b1) begin cap_sa.push_back(s_addr); cap_sd.push_back(s_data); end
      if (b_done === 1'b1) b_done_cnt++;
      if (s_done === 1'b1) s_done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; line_start = 1'b0; pix_valid = 1'b0; pix_data = 1'b0;
    tick(); tick();
    reset = 1'b0;
    cap_ba.delete(); cap_bd.delete(); cap_sa.delete(); cap_sd.delete();
    b_done_cnt = 0; s_done_cnt = 0;
  endtask

  task automatic start_line();
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic send_px(input logic b);
    pix_valid = 1'b1;
    pix_data  = b;
    tick();
    pix_valid = 1'b0;
  endtask

  logic [3:0] w_exp;
  logic [3:0] bp_px;
  logic [7:0] sm_px;
  int         bad;

  initial begin
    // Reset state
    tick(); tick();
    chk("reset.wr_ce", b_ce, 1'b0);
    chk("reset.wr_addr", b_addr, 7'd0);
    chk("reset.busy", b_busy, 1'b0);
    do_reset();

    // Full line: pattern 1,0,0,0 back-to-back
    start_line();
    for (int i = 0; i < 512; i++) send_px(i % 4 == 0);
    tick(); tick();
`ifdef LINECACHE_PACKER_MSB_FIRST_EN
    w_exp = 4'b1000;
`else
    w_exp = 4'b0001;
`endif
    chk("full.write_count", cap_ba.size(), 128);
    chk("full.done_count", b_done_cnt, 1);
    chk("full.overrun", b_ovr, 1'b0);
    bad = 0;
    for (int i = 0; i < cap_ba.size() && i < 128; i++)
      if (cap_ba[i] !== 7'(i) || cap_bd[i] !== w_exp) bad++;
    chk("full.addr_data_order", bad, 0);

    // Back-pressure: valid toggling 1,0 with pixels 1,1,0,1
    do_reset();
    start_line();
    bp_px = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      pix_valid = 1'b1;
      pix_data  = bp_px[i];
      tick();
      pix_valid = 1'b0;
      if (i == 3) chk("bp.ce_latency", b_ce, 1'b1);
      else begin
        chk("bp.no_early_ce", b_ce, 1'b0);
        tick();
      end
    end
    tick();
`ifdef LINECACHE_PACKER_MSB_FIRST_EN
    w_exp = 4'b1101;
`else
    w_exp = 4'b1011;
`endif
    chk("bp.write_count", cap_bd.size(), 1);
    chk("bp.word0", (cap_bd.size() > 0) ? cap_bd[0] : 4'bx, w_exp);

    // Abort after 6 pixels, then a full line
    do_reset();
    start_line();
    for (int i = 0; i < 6; i++) send_px(i % 2 == 0);
    start_line();
    for (int i = 0; i < 512; i++) send_px(i % 3 == 0);
    tick(); tick();
    chk("abort.overrun", b_ovr, 1'b1);
    chk("abort.done_count", b_done_cnt, 1);
    chk("abort.write_count", cap_ba.size(), 129);
    chk("abort.restart_addr", (cap_ba.size() > 1) ? cap_ba[1] : 7'bx, 7'd0);
    chk("abort.last_addr", (cap_ba.size() > 128) ? cap_ba[128] : 7'bx, 7'd127);

    // Small line on the 8-pixel instance
    do_reset();
    start_line();
    sm_px = 8'b0000_1111;
    for (int i = 0; i < 8; i++) send_px(sm_px[i]);
    tick();
    chk("small.write_count", cap_sa.size(), 2);
    chk("small.addr0", (cap_sa.size() > 0) ? cap_sa[0] : 1'bx, 1'b0);
    chk("small.data0", (cap_sd.size() > 0) ? cap_sd[0] : 4'bx, 4'hF);
    chk("small.addr1", (cap_sa.size() > 1) ? cap_sa[1] : 1'bx, 1'b1);
    chk("small.data1", (cap_sd.size() > 1) ? cap_sd[1] : 4'bx, 4'h0);
    chk("small.done_count", s_done_cnt, 1);
    pix_valid = 1'b1; pix_data = 1'b1;
    #1;
    chk("small.idle_ready", s_rdy, 1'b0);
    tick();
    pix_valid = 1'b0;

    // Reset on the edge that accepts pixel 3
    do_reset();
    start_line();
    send_px(1'b1); send_px(1'b0); send_px(1'b1);
    pix_valid = 1'b1; pix_data = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; pix_valid = 1'b0;
    chk("rst_mid.wr_ce", b_ce, 1'b0);
    chk("rst_mid.wr_addr", b_addr, 7'd0);
    chk("rst_mid.wr_data", b_data, 4'd0);
    chk("rst_mid.line_done", b_done, 1'b0);
    chk("rst_mid.busy", b_busy, 1'b0);
    chk("rst_mid.overrun", b_ovr, 1'b0);
    tick(); tick(); tick();
    chk("rst_mid.no_write", cap_ba.size(), 0);

    // line_start together with pix_valid, in IDLE and in FILL
    do_reset();
    line_start = 1'b1; pix_valid = 1'b1; pix_data = 1'b1;
    #1;
    chk("same.idle_ready", b_rdy, 1'b0);
    tick();
    line_start = 1'b0; pix_valid = 1'b0;
    send_px(1'b1); send_px(1'b1);
    line_start = 1'b1; pix_valid = 1'b1; pix_data = 1'b1;
    #1;
    chk("same.fill_ready", b_rdy, 1'b0);
    tick();
    line_start = 1'b0; pix_valid = 1'b0;
    chk("same.overrun", b_ovr, 1'b1);
    send_px(1'b0); send_px(1'b1); send_px(1'b1); send_px(1'b1);
    tick();
`ifdef LINECACHE_PACKER_MSB_FIRST_EN
    w_exp = 4'b0111;
`else
    w_exp = 4'b1110;
`endif
    chk("same.write_count", cap_bd.size(), 1);
    chk("same.word0", (cap_bd.size() > 0) ? cap_bd[0] : 4'bx, w_exp);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
